cmd_frame_parser: RTL

- Consumes the synchronized byte stream produced by the bus synchronizer: an 8-bit bus plus a one-cycle enable pulse, in the destination clock domain.
- Assembles multi-byte command frames (register write, register read, ALU with operands, ALU without operands).
- Presents each completed frame as one decoded command on a valid/ready interface to the system controller.
- Aborts stalled frames by timeout and flags unknown opcodes and dropped bytes.

---
 rtl/cmd_frame_parser_pkg.sv | 35 +++
 rtl/cmd_frame_parser_if.sv | 38 +++
 rtl/cmd_frame_parser_frame_timer.sv | 29 ++
 rtl/cmd_frame_parser.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/cmd_frame_parser_pkg.sv
// Shared constants and types for the command frame parser: opcode bytes,
// decoded command encodings, error codes and the parser FSM state type.
package cmd_parser_pkg;

  localparam logic [7:0] OPC_WR      = 8'hAA;
  localparam logic [7:0] OPC_RD      = 8'hBB;
  localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
  localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    CMD_WR      = 2'b00,
    CMD_RD      = 2'b01,
    CMD_ALU_OP  = 2'b10,
    CMD_ALU_NOP = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_UNKNOWN = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_OVERRUN = 2'b11
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_ALU_A,
    ST_ALU_B,
    ST_ALU_FUN,
    ST_OUT
  } state_e;

endpackage

// File: rtl/cmd_frame_parser_if.sv
// Byte-stream input, decoded-command valid/ready output and error strobe of
// the parser; slave is the parser's view, master the producer/consumer side.
interface cmd_frame_parser_if
  import cmd_parser_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
);

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;

  logic                  cmd_valid;
  logic                  cmd_ready;
  cmd_op_e               cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [DATA_WIDTH-1:0] cmd_opa;
  logic [DATA_WIDTH-1:0] cmd_opb;
  logic [FUN_WIDTH-1:0]  cmd_fun;

  logic                  err_pulse;
  err_code_e             err_code;

  modport master (
    output rx_data, rx_valid, cmd_ready,
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_opa, cmd_opb, cmd_fun,
    input  err_pulse, err_code
  );

  modport slave (
    input  rx_data, rx_valid, cmd_ready,
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_opa, cmd_opb, cmd_fun,
    output err_pulse, err_code
  );

endinterface

// File: rtl/cmd_frame_parser_frame_timer.sv
// Saturating inter-byte idle counter; o_expired is high on the cycle that
// would be the TIMEOUT_CYCLES-th consecutive enabled cycle.
module frame_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CW'(TIMEOUT_CYCLES))) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = i_enable && !i_clear && (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cmd_frame_parser.sv
// Assembles opcode-led byte frames into decoded commands presented on a
// valid/ready handshake, with timeout, unknown-opcode and overrun reporting.
module cmd_frame_parser
  import cmd_parser_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               i_clk,
  input logic               i_rst,
  cmd_frame_parser_if.slave io_bus
);

  state_e                r_state;
  logic                  r_cmd_valid;
  cmd_op_e               r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_opa;
  logic [DATA_WIDTH-1:0] r_opb;
  logic [FUN_WIDTH-1:0]  r_fun;
  logic                  r_err_pulse;
  err_code_e             r_err_code;

  logic    w_opc_known;
  cmd_op_e w_opc_op;
  state_e  w_opc_state;
  logic    w_in_field;
  logic    w_xfer;
  logic    w_take_opcode;
  logic    w_tmr_en;
  logic    w_tmr_expired;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_opc_known = 1'b1;
    w_opc_op    = CMD_WR;
    w_opc_state = ST_WR_ADDR;
    if (io_bus.rx_data == DATA_WIDTH'(OPC_WR)) begin
      w_opc_op    = CMD_WR;
      w_opc_state = ST_WR_ADDR;
    end else if (io_bus.rx_data == DATA_WIDTH'(OPC_RD)) begin
      w_opc_op    = CMD_RD;
      w_opc_state = ST_RD_ADDR;
    end else if (io_bus.rx_data == DATA_WIDTH'(OPC_ALU_OP)) begin
      w_opc_op    = CMD_ALU_OP;
      w_opc_state = ST_ALU_A;
    end else if (io_bus.rx_data == DATA_WIDTH'(OPC_ALU_NOP)) begin
      w_opc_op    = CMD_ALU_NOP;
      w_opc_state = ST_ALU_FUN;
    end else begin
      w_opc_known = 1'b0;
    end
  end

  assign w_in_field = (r_state != ST_IDLE) && (r_state != ST_OUT);
  assign w_xfer     = r_cmd_valid && io_bus.cmd_ready;
  // A byte arriving together with a transfer starts the next frame directly.
  assign w_take_opcode = io_bus.rx_valid &&
                         ((r_state == ST_IDLE) || ((r_state == ST_OUT) && w_xfer));
  assign w_tmr_en = w_in_field && !io_bus.rx_valid;

  frame_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (!w_tmr_en),
    .i_enable  (w_tmr_en),
    .o_expired (w_tmr_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cmd_valid <= 1'b0;
      r_op        <= CMD_WR;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_fun       <= '0;
      r_err_pulse <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_err_pulse <= 1'b0;
      if (w_xfer) begin
        r_cmd_valid <= 1'b0;
      end

      if (w_take_opcode) begin
        if (w_opc_known) begin
          r_op    <= w_opc_op;
          r_state <= w_opc_state;
        end else begin
          r_err_pulse <= 1'b1;
          r_err_code  <= ERR_UNKNOWN;
          r_state     <= ST_IDLE;
        end
      end else if (w_tmr_expired) begin
        r_err_pulse <= 1'b1;
        r_err_code  <= ERR_TIMEOUT;
        r_state     <= ST_IDLE;
      end else if (r_state == ST_OUT) begin
        if (w_xfer) begin
          r_state <= ST_IDLE;
        end else if (io_bus.rx_valid) begin
          r_err_pulse <= 1'b1;
          r_err_code  <= ERR_OVERRUN;
        end
      end else if (io_bus.rx_valid) begin
        unique case (r_state)
          ST_WR_ADDR: begin
            r_addr  <= io_bus.rx_data[ADDR_WIDTH-1:0];
            r_state <= ST_WR_DATA;
          end
          ST_WR_DATA: begin
            r_wdata     <= io_bus.rx_data;
            r_cmd_valid <= 1'b1;
            r_state     <= ST_OUT;
          end
          ST_RD_ADDR: begin
            r_addr      <= io_bus.rx_data[ADDR_WIDTH-1:0];
            r_cmd_valid <= 1'b1;
            r_state     <= ST_OUT;
          end
          ST_ALU_A: begin
            r_opa   <= io_bus.rx_data;
            r_state <= ST_ALU_B;
          end
          ST_ALU_B: begin
            r_opb   <= io_bus.rx_data;
            r_state <= ST_ALU_FUN;
          end
          ST_ALU_FUN: begin
            r_fun       <= io_bus.rx_data[FUN_WIDTH-1:0];
            r_cmd_valid <= 1'b1;
            r_state     <= ST_OUT;
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  assign io_bus.cmd_valid = r_cmd_valid;
  assign io_bus.cmd_op    = r_op;
  assign io_bus.cmd_addr  = r_addr;
  assign io_bus.cmd_wdata = r_wdata;
  assign io_bus.cmd_opa   = r_opa;
  assign io_bus.cmd_opb   = r_opb;
  assign io_bus.cmd_fun   = r_fun;
  assign io_bus.err_pulse = r_err_pulse;
  assign io_bus.err_code  = r_err_code;

endmodule
